// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the single-beat stb/ack bus.
// The granted master passes straight through; a watchdog ends stalled transfers with an error ack.
module bus_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        m0_stb_i,
    input  logic        m1_stb_i,
    input  logic        m0_we_i,
    input  logic        m1_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [3:0]  m1_sel_i,
    output logic        m0_ack_o,
    output logic        m1_ack_o,
    output logic        m0_err_o,
    output logic        m1_err_o,
    output logic [31:0] m0_dat_o,
    output logic [31:0] m1_dat_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  gnt_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Selected master's request, muxed by the current owner.
    logic          owner;
    logic          own_stb;
    logic          own_we;
    logic [31:0]   own_adr;
    logic [31:0]   own_dat;
    logic [3:0]    own_sel;
    logic          timeout;
    logic          own_ack;
    logic [31:0]   own_rdat;

    // NOTE: state registers use non-blocking assignments; the async reset also restores
    // the pointer so m0 wins the first tie after any reset.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt_o    = 2'b00;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;

        owner    = (state_q == GRANT1);
        own_stb  = owner ? m1_stb_i : m0_stb_i;
        own_we   = owner ? m1_we_i  : m0_we_i;
        own_adr  = owner ? m1_adr_i : m0_adr_i;
        own_dat  = owner ? m1_dat_i : m0_dat_i;
        own_sel  = owner ? m1_sel_i : m0_sel_i;
        timeout  = own_stb && !s_ack_i && (cnt_q == CNT_LAST);
        own_ack  = (s_ack_i && own_stb) || timeout;
        own_rdat = timeout ? ERR_DATA : s_dat_i;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_stb_i && m1_stb_i) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                    last_d  = ~last_q;
                end else if (m0_stb_i) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                end else if (m1_stb_i) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                gnt_o   = owner ? 2'b10 : 2'b01;
                s_stb_o = own_stb && !timeout;
                s_we_o  = own_we;
                s_adr_o = own_adr;
                s_dat_o = own_dat;
                s_sel_o = own_sel;
                if (owner) begin
                    m1_ack_o = own_ack;
                    m1_err_o = timeout;
                    m1_dat_o = own_rdat;
                end else begin
                    m0_ack_o = own_ack;
                    m0_err_o = timeout;
                    m0_dat_o = own_rdat;
                end
                if (!s_ack_i && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Ack, abort or watchdog expiry all force a bubble cycle in IDLE.
                if (!own_stb || s_ack_i || timeout) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: a transaction-level model predicts every output each cycle,
// with directed sequences that pin reset, grant order, timeout and abort behaviour to literals.
module tb_bus_arbiter;

    localparam int unsigned TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [1:0]  m_stb, m_we;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic [1:0]  m_ack, m_err;
    logic [31:0] m_dat_o [2];
    logic        s_stb_o, s_we_o, s_ack_i;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic [1:0]  gnt_o;

    int n_cmp = 0;
    int n_err = 0;

    bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .m0_stb_i(m_stb[0]), .m1_stb_i(m_stb[1]),
        .m0_we_i(m_we[0]), .m1_we_i(m_we[1]),
        .m0_adr_i(m_adr[0]), .m1_adr_i(m_adr[1]),
        .m0_dat_i(m_dat[0]), .m1_dat_i(m_dat[1]),
        .m0_sel_i(m_sel[0]), .m1_sel_i(m_sel[1]),
        .m0_ack_o(m_ack[0]), .m1_ack_o(m_ack[1]),
        .m0_err_o(m_err[0]), .m1_err_o(m_err[1]),
        .m0_dat_o(m_dat_o[0]), .m1_dat_o(m_dat_o[1]),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .gnt_o(gnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the bus, how long it has waited, who was granted last.
    int own = -1, waited = 0, last = 1;
    int nxt_own = -1, nxt_wait = 0, nxt_last = 1;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            own = -1; waited = 0; last = 1;
        end else begin
            own = nxt_own; waited = nxt_wait; last = nxt_last;
        end
    end

    logic [1:0]  e_gnt, e_ack, e_err;
    logic        e_stb, e_we;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic [31:0] e_mdat [2];

    always @(negedge clk) begin
        e_gnt = 2'b00; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
        e_ack = 2'b00; e_err = 2'b00; e_mdat[0] = '0; e_mdat[1] = '0;
        nxt_own = own; nxt_wait = waited; nxt_last = last;
        if (!rst_ni) begin
            nxt_own = -1; nxt_wait = 0; nxt_last = 1;
        end else if (own < 0) begin
            nxt_wait = 0;
            if (m_stb == 2'b11) nxt_own = 1 - last;
            else if (m_stb[0]) nxt_own = 0;
            else if (m_stb[1]) nxt_own = 1;
            if (nxt_own >= 0) nxt_last = nxt_own;
        end else begin
            e_gnt = (own == 0) ? 2'b01 : 2'b10;
            e_stb = m_stb[own];
            e_we  = m_we[own];
            e_adr = m_adr[own];
            e_dat = m_dat[own];
            e_sel = m_sel[own];
            e_mdat[own] = s_dat_i;
            e_ack[own]  = s_ack_i & m_stb[own];
            if (!m_stb[own] || s_ack_i) begin
                nxt_own = -1;
            end else if (waited == int'(TO) - 1) begin
                e_stb = 1'b0; e_ack[own] = 1'b1; e_err[own] = 1'b1; e_mdat[own] = ERR;
                nxt_own = -1;
            end else begin
                nxt_wait = waited + 1;
            end
        end
        check("gnt", 32'(gnt_o), 32'(e_gnt));
        check("s_stb", 32'(s_stb_o), 32'(e_stb));
        check("s_we", 32'(s_we_o), 32'(e_we));
        check("s_adr", s_adr_o, e_adr);
        check("s_dat", s_dat_o, e_dat);
        check("s_sel", 32'(s_sel_o), 32'(e_sel));
        check("ack", 32'(m_ack), 32'(e_ack));
        check("err", 32'(m_err), 32'(e_err));
        check("m0_dat", m_dat_o[0], e_mdat[0]);
        check("m1_dat", m_dat_o[1], e_mdat[1]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic new_req(input int i);
        m_stb[i] = 1'b1;
        m_we[i]  = 1'($urandom);
        m_adr[i] = $urandom;
        m_dat[i] = $urandom;
        m_sel[i] = 4'($urandom);
    endtask

    logic [1:0] seq [8];
    logic [1:0] prev_ack;
    int         ack_div;

    initial begin
        rst_ni = 1'b0; m_stb = 2'b11; m_we = 2'b00; s_ack_i = 1'b0; s_dat_i = '0;
        m_adr[0] = 32'h1000_0000; m_adr[1] = 32'h2000_0004;
        m_dat[0] = 32'hA0A0_0000; m_dat[1] = 32'hB0B0_0000;
        m_sel[0] = 4'hF; m_sel[1] = 4'h3;

        // Reset held with both requesting, then the first tie goes to m0.
        repeat (3) @(posedge clk);
        look();
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_stb", 32'(s_stb_o), 32'h0);
        step(); rst_ni = 1'b1;
        look(); check("post_rst_idle", 32'(gnt_o), 32'h0);
        step(); s_ack_i = 1'b1;
        look();
        check("first_tie_gnt", 32'(gnt_o), 32'h1);
        check("first_tie_adr", s_adr_o, 32'h1000_0000);
        check("first_tie_ack", 32'(m_ack), 32'h1);
        step(); m_stb = 2'b00; s_ack_i = 1'b0;
        look();

        // Single read by m1, slave answers two cycles after the strobe.
        step(); m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h0000_0010;
        look();
        step(); look(); check("rd_stb", 32'(s_stb_o), 32'h1); check("rd_gnt", 32'(gnt_o), 32'h2);
        step(); look();
        step(); s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
        look();
        check("rd_ack", 32'(m_ack[1]), 32'h1);
        check("rd_data", m_dat_o[1], 32'h1234_5678);
        check("rd_err", 32'(m_err[1]), 32'h0);
        check("rd_m0_ack", 32'(m_ack[0]), 32'h0);
        step(); m_stb[1] = 1'b0; s_ack_i = 1'b0;
        look(); check("rd_ack_once", 32'(m_ack[1]), 32'h0);

        // Contention with immediate acks: alternating grants with a bubble between each.
        seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        step(); m_stb = 2'b11; m_we = 2'b11; s_ack_i = 1'b1;
        for (int j = 0; j < 8; j++) begin
            look(); check($sformatf("rr_gnt%0d", j), 32'(gnt_o), 32'(seq[j]));
            step();
        end
        m_stb = 2'b00; s_ack_i = 1'b0;
        look();

        // Watchdog: no ack ever, error ack on the 8th cycle after the request is seen.
        step(); m_stb[0] = 1'b1; s_dat_i = 32'h5555_AAAA;
        look();
        for (int c = 1; c <= 8; c++) begin
            step(); look();
            if (c == 7) begin
                check("to_pre_ack", 32'(m_ack[0]), 32'h0);
                check("to_pre_stb", 32'(s_stb_o), 32'h1);
            end
        end
        check("to_ack", 32'(m_ack[0]), 32'h1);
        check("to_err", 32'(m_err[0]), 32'h1);
        check("to_data", m_dat_o[0], 32'hDEAD_BEEF);
        check("to_stb", 32'(s_stb_o), 32'h0);
        step(); m_stb[0] = 1'b0;
        look(); check("to_idle", 32'(gnt_o), 32'h0);

        // Ack arriving on the timeout cycle wins.
        step(); m_stb[0] = 1'b1;
        look();
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 8) begin s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0001; end
            look();
        end
        check("col_ack", 32'(m_ack[0]), 32'h1);
        check("col_err", 32'(m_err[0]), 32'h0);
        check("col_data", m_dat_o[0], 32'hCAFE_0001);
        step(); m_stb[0] = 1'b0; s_ack_i = 1'b0;
        look();

        // Abort by m1.
        step(); m_stb[1] = 1'b1; look();
        step(); look(); check("ab_gnt", 32'(gnt_o), 32'h2);
        step(); m_stb[1] = 1'b0;
        look(); check("ab_ack", 32'(m_ack[1]), 32'h0); check("ab_stb", 32'(s_stb_o), 32'h0);
        step(); look(); check("ab_idle", 32'(gnt_o), 32'h0);

        // Reset during GRANT0 drops the strobe at once and restores m0's tie priority.
        step(); m_stb[0] = 1'b1; look();
        step(); look(); check("mr_gnt", 32'(gnt_o), 32'h1);
        step(); rst_ni = 1'b0;
        #1;
        check("mr_stb_async", 32'(s_stb_o), 32'h0);
        check("mr_gnt_async", 32'(gnt_o), 32'h0);
        look();
        step(); rst_ni = 1'b1; m_stb = 2'b11;
        look();
        step(); look(); check("mr_tie_m0", 32'(gnt_o), 32'h1);
        step(); m_stb = 2'b00;
        look();

        // Randomized traffic, alternating fast and slow slave phases.
        prev_ack = 2'b00;
        ack_div = 2;
        for (int n = 0; n < 3000; n++) begin
            step();
            if (n % 200 == 0) ack_div = ($urandom % 2 == 0) ? 2 : 12;
            for (int i = 0; i < 2; i++) begin
                if (m_stb[i]) begin
                    if (prev_ack[i]) begin
                        if ($urandom % 2 == 0) new_req(i);
                        else m_stb[i] = 1'b0;
                    end else if ($urandom % 40 == 0) begin
                        m_stb[i] = 1'b0;
                    end
                end else if ($urandom % 3 == 0) begin
                    new_req(i);
                end
            end
            s_ack_i = ($urandom % ack_div == 0);
            s_dat_i = $urandom;
            look();
            prev_ack = m_ack;
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
